// File: rtl/tq_premuat_pipe.sv
// Registered even/odd lane reorder stage for the tq datapath, with a 2-entry skid buffer
// so the upstream ready comes straight from a flop.
module tq_premuat_pipe #(
    parameter int WIDTH = 16,
    parameter int N     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic                 i_enable,
    input  logic                 i_inverse,
    input  logic [1:0]           i_size,
    input  logic [N*WIDTH-1:0]   i_data,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [1:0]           o_size,
    output logic                 o_inverse,
    output logic [N*WIDTH-1:0]   o_data
);

    // Source lane feeding output lane 'lane' for a given size code and direction.
    // Sizes wider than N, and lanes beyond the TU, map to themselves.
    function automatic int src_lane(input int lane, input int sz, input int inv);
        int n;
        int h;
        n = 4 << sz;
        h = n / 2;
        if (n > N || lane >= n)
            return lane;
        if (inv != 0)
            return (lane < h) ? 2 * lane : 2 * (lane - h) + 1;
        return ((lane % 2) == 0) ? lane / 2 : lane / 2 + h;
    endfunction

    logic [N*WIDTH-1:0] perm_data;

    // Every output lane picks among 8 statically routed candidates (4 sizes x 2 directions).
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            logic [WIDTH-1:0] cand [8];
            for (genvar gs = 0; gs < 4; gs++) begin : g_size
                for (genvar gv = 0; gv < 2; gv++) begin : g_dir
                    assign cand[gs*2+gv] = i_data[src_lane(gi, gs, gv)*WIDTH +: WIDTH];
                end
            end
            assign perm_data[gi*WIDTH +: WIDTH] = i_enable ? cand[{i_size, i_inverse}]
                                                           : i_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic               out_valid_reg;
    logic [1:0]         out_size_reg;
    logic               out_inverse_reg;
    logic [N*WIDTH-1:0] out_data_reg;
    logic               skid_valid_reg;
    logic [1:0]         skid_size_reg;
    logic               skid_inverse_reg;
    logic [N*WIDTH-1:0] skid_data_reg;
    logic               ready_reg;
    logic               accept;

    assign accept = i_valid & ready_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg    <= 1'b0;
            out_size_reg     <= '0;
            out_inverse_reg  <= 1'b0;
            out_data_reg     <= '0;
            skid_valid_reg   <= 1'b0;
            skid_size_reg    <= '0;
            skid_inverse_reg <= 1'b0;
            skid_data_reg    <= '0;
            ready_reg        <= 1'b1;
        end else begin
            if (!out_valid_reg || o_ready) begin
                // Output slot is free this edge; the skid entry is older, so it goes first.
                if (skid_valid_reg) begin
                    out_valid_reg   <= 1'b1;
                    out_size_reg    <= skid_size_reg;
                    out_inverse_reg <= skid_inverse_reg;
                    out_data_reg    <= skid_data_reg;
                    skid_valid_reg  <= 1'b0;
                    ready_reg       <= 1'b1;
                end else if (accept) begin
                    out_valid_reg   <= 1'b1;
                    out_size_reg    <= i_size;
                    out_inverse_reg <= i_inverse;
                    out_data_reg    <= perm_data;
                end else begin
                    out_valid_reg   <= 1'b0;
                end
            end else if (accept) begin
                skid_valid_reg   <= 1'b1;
                skid_size_reg    <= i_size;
                skid_inverse_reg <= i_inverse;
                skid_data_reg    <= perm_data;
                ready_reg        <= 1'b0;
            end
        end
    end

    assign i_ready   = ready_reg;
    assign o_valid   = out_valid_reg;
    assign o_size    = out_size_reg;
    assign o_inverse = out_inverse_reg;
    assign o_data    = out_data_reg;

endmodule

// File: tb/tb_tq_premuat_pipe.sv
// Directed and scoreboarded checks for the tq even/odd reorder stage.
module tb_tq_premuat_pipe;
    localparam int W  = 16;
    localparam int N  = 32;
    localparam int DW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic          i_enable;
    logic          i_inverse;
    logic [1:0]    i_size;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [1:0]    o_size;
    logic          o_inverse;
    logic [DW-1:0] o_data;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    s;
        logic          v;
    } beat_t;
    beat_t q[$];

    int exp3 [8] = '{0, 4, 1, 5, 2, 6, 3, 7};

    always #5 clk = ~clk;

    tq_premuat_pipe #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
        .i_enable(i_enable), .i_inverse(i_inverse), .i_size(i_size), .i_data(i_data),
        .o_valid(o_valid), .o_ready(o_ready), .o_size(o_size), .o_inverse(o_inverse),
        .o_data(o_data)
    );

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        total++;
        if (obs !== exp)
            $display("FAIL %s: got %h required %h", tag, obs, exp);
        else
            passed++;
    endtask

    function automatic logic [DW-1:0] e(input logic [31:0] x);
        e = '0;
        e[31:0] = x;
    endfunction

    function automatic logic [DW-1:0] lane_of(input logic [DW-1:0] v, input int k);
        lane_of = '0;
        lane_of[W-1:0] = v[k*W +: W];
    endfunction

    function automatic logic [DW-1:0] ramp(input int off);
        for (int k = 0; k < N; k++) ramp[k*W +: W] = 16'(k + off);
    endfunction

    // Reference permutation written from the input side (scatter), one TU at a time.
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [1:0] sz,
                                            input logic inv, input logic en);
        int n, h;
        model = d;
        n = 4 << sz;
        h = n / 2;
        if (en && n <= N) begin
            for (int k = 0; k < h; k++) begin
                if (!inv) begin
                    model[(2*k)*W +: W]   = d[k*W +: W];
                    model[(2*k+1)*W +: W] = d[(k+h)*W +: W];
                end else begin
                    model[k*W +: W]     = d[(2*k)*W +: W];
                    model[(k+h)*W +: W] = d[(2*k+1)*W +: W];
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d, input logic [1:0] sz,
                         input logic inv, input logic en);
        i_valid = v; i_data = d; i_size = sz; i_inverse = inv; i_enable = en;
    endtask

    initial begin
        int acc;
        int cyc;
        beat_t b;
        rst = 1'b1; o_ready = 1'b0;
        drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_o_valid", e(32'(o_valid)), e(0));
        check("rst_o_data", o_data, '0);
        check("rst_o_size_inv", e(32'({o_size, o_inverse})), e(0));
        check("rst_i_ready", e(32'(i_ready)), e(1));
        rst = 1'b0;

        // size 32 forward, latency 1
        o_ready = 1'b1;
        drive(1'b1, ramp(0), 2'd3, 1'b0, 1'b1);
        check("t1_pre_valid", e(32'(o_valid)), e(0));
        tick();
        $display("t1 fwd size=32 beat out");
        check("t1_valid", e(32'(o_valid)), e(1));
        check("t1_l1", lane_of(o_data, 1), e(16));
        check("t1_l2", lane_of(o_data, 2), e(1));
        check("t1_l3", lane_of(o_data, 3), e(17));
        check("t1_l30", lane_of(o_data, 30), e(15));
        check("t1_l31", lane_of(o_data, 31), e(31));
        check("t1_ctl", e(32'({o_size, o_inverse})), e(6));

        // size 32 inverse
        drive(1'b1, ramp(0), 2'd3, 1'b1, 1'b1);
        tick();
        $display("t2 inv size=32 beat out");
        check("t2_l1", lane_of(o_data, 1), e(2));
        check("t2_l2", lane_of(o_data, 2), e(4));
        check("t2_l15", lane_of(o_data, 15), e(30));
        check("t2_l16", lane_of(o_data, 16), e(1));
        check("t2_l31", lane_of(o_data, 31), e(31));
        check("t2_ctl", e(32'({o_size, o_inverse})), e(7));

        // size 8 forward, upper lanes untouched
        drive(1'b1, ramp(0), 2'd1, 1'b0, 1'b1);
        tick();
        $display("t3 fwd size=8 beat out");
        for (int k = 0; k < 8; k++) check($sformatf("t3_l%0d", k), lane_of(o_data, k), e(exp3[k]));
        for (int k = 8; k < N; k++) check($sformatf("t3_hi%0d", k), lane_of(o_data, k), e(k));

        // bypass
        drive(1'b1, ramp(0), 2'd3, 1'b0, 1'b0);
        tick();
        $display("t3 bypass beat out");
        check("t3_bypass", o_data, ramp(0));

        // size 4 forward
        drive(1'b1, ramp(0), 2'd0, 1'b0, 1'b1);
        tick();
        $display("t3 fwd size=4 beat out");
        check("t3_s4_l1", lane_of(o_data, 1), e(2));
        check("t3_s4_l2", lane_of(o_data, 2), e(1));
        check("t3_s4_l4", lane_of(o_data, 4), e(4));

        i_valid = 1'b0;
        tick();
        check("drain_valid", e(32'(o_valid)), e(0));

        // backpressure: A in output, B in skid
        o_ready = 1'b0;
        drive(1'b1, ramp(100), 2'd2, 1'b1, 1'b0);
        tick();
        $display("t4 beat A accepted");
        check("t4_a_ready", e(32'(i_ready)), e(1));
        drive(1'b1, ramp(200), 2'd1, 1'b0, 1'b0);
        tick();
        $display("t4 beat B accepted");
        check("t4_b_ready", e(32'(i_ready)), e(0));
        check("t4_hold_a", o_data, ramp(100));
        i_valid = 1'b0;
        tick();
        check("t4_stall_a", o_data, ramp(100));
        check("t4_stall_ctl", e(32'({o_size, o_inverse})), e(5));
        o_ready = 1'b1;
        tick();
        $display("t4 beat A out, B moves up");
        check("t4_b_data", o_data, ramp(200));
        check("t4_b_ctl", e(32'({o_size, o_inverse, o_valid})), e(5));
        check("t4_ready_back", e(32'(i_ready)), e(1));
        tick();
        check("t4_empty", e(32'(o_valid)), e(0));

        // async reset with both entries full
        o_ready = 1'b0;
        drive(1'b1, ramp(400), 2'd0, 1'b0, 1'b0);
        tick();
        drive(1'b1, ramp(500), 2'd0, 1'b0, 1'b0);
        tick();
        check("t6_full", e(32'(i_ready)), e(0));
        i_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        $display("t6 reset mid-transfer");
        check("t6_valid", e(32'(o_valid)), e(0));
        check("t6_data", o_data, '0);
        check("t6_ready", e(32'(i_ready)), e(1));
        #2 rst = 1'b0;
        o_ready = 1'b1;
        drive(1'b1, ramp(300), 2'd0, 1'b0, 1'b0);
        tick();
        $display("t6 first beat after reset");
        check("t6_first", o_data, ramp(300));
        check("t6_first_valid", e(32'(o_valid)), e(1));
        i_valid = 1'b0;
        tick();
        check("t6_no_ghost", e(32'(o_valid)), e(0));

        // random traffic against the scoreboard
        acc = 0;
        cyc = 0;
        while ((acc < 200 || q.size() != 0) && cyc < 5000) begin
            logic [DW-1:0] d;
            for (int k = 0; k < N; k++) d[k*W +: W] = 16'($urandom);
            drive(acc < 200 && ($urandom % 4 != 0), d, 2'($urandom), 1'($urandom), 1'($urandom % 4 != 0));
            o_ready = ($urandom % 3 != 0);
            #1;
            if (i_valid && i_ready) begin
                b.d = model(i_data, i_size, i_inverse, i_enable);
                b.s = i_size;
                b.v = i_inverse;
                q.push_back(b);
                acc++;
            end
            if (o_valid && o_ready) begin
                if (q.size() == 0) begin
                    check("rnd_extra_beat", e(32'(o_valid)), e(0));
                end else begin
                    b = q.pop_front();
                    check("rnd_data", o_data, b.d);
                    check("rnd_ctl", e(32'({o_size, o_inverse})), e(32'({b.s, b.v})));
                    $display("rnd beat out size=%0d inv=%0d", o_size, o_inverse);
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rnd_accepted", e(32'(acc)), e(200));
        check("rnd_queue_empty", e(32'(q.size())), e(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
